fetch_stage: RTL and testbench

- Instruction-fetch stage of the RV32E pipeline.
- Owns the PC and issues requests to instruction memory over a single-outstanding request/grant/response handshake.
- Fills the IF/ID pipeline register and consumes the redirect (branch_taken/branch_target) produced by the execute stage.
- Honours the hazard-unit stall and drains stale responses after a redirect.

---
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32E instruction fetch with a single-outstanding imem handshake,
// a 1-entry skid buffer behind the IF/ID register and redirect draining.
module fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_id_valid,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic [PC_WIDTH-1:0] if_id_pc_plus4,
    output logic [31:0]         if_id_instr,
    output logic                misaligned
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d, if_pc4_q, if_pc4_d, skid_pc_q, skid_pc_d;
    logic [31:0]         if_instr_q, if_instr_d, skid_instr_q, skid_instr_d;
    logic                ifv_q, ifv_d, skid_v_q, skid_v_d, mis_q, mis_d;
    logic                grant, resp, take;

    // A full skid buffer throttles fetch so at most two instructions are ever held.
    assign imem_req       = (state_q == REQ) && !skid_v_q;
    assign imem_addr      = pc_q;
    assign grant          = imem_req && imem_gnt;
    assign resp           = (state_q == WAIT) && imem_rvalid;
    assign take           = !ifv_q || !stall;
    assign if_id_valid    = ifv_q;
    assign if_id_pc       = if_pc_q;
    assign if_id_pc_plus4 = if_pc4_q;
    assign if_id_instr    = if_instr_q;
    assign misaligned     = mis_q;

    always_comb begin
        pc_d         = grant ? pc_q + PC_WIDTH'(4) : pc_q;
        req_pc_d     = grant ? pc_q : req_pc_q;
        state_d      = state_q == IDLE ? REQ :
                       state_q == REQ  ? (grant ? WAIT : REQ) :
                       imem_rvalid     ? REQ : state_q;
        ifv_d        = ifv_q;
        if_pc_d      = if_pc_q;
        if_pc4_d     = if_pc4_q;
        if_instr_d   = if_instr_q;
        skid_v_d     = skid_v_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        mis_d        = redirect && (redirect_target[1:0] != 2'b00);
        if (take) begin
            ifv_d = skid_v_q || resp;
            if (skid_v_q) begin
                if_pc_d    = skid_pc_q;
                if_pc4_d   = skid_pc_q + PC_WIDTH'(4);
                if_instr_d = skid_instr_q;
                skid_v_d   = 1'b0;
            end else if (resp) begin
                if_pc_d    = req_pc_q;
                if_pc4_d   = req_pc_q + PC_WIDTH'(4);
                if_instr_d = imem_rdata;
            end
        end else if (resp) begin
            skid_v_d     = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem_rdata;
        end
        // A response still owed to a pre-redirect request must be swallowed in DRAIN.
        if (redirect) begin
            pc_d     = {redirect_target[PC_WIDTH-1:2], 2'b00};
            ifv_d    = 1'b0;
            skid_v_d = 1'b0;
            state_d  = (grant || ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid)) ? DRAIN : REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            ifv_q        <= 1'b0;
            if_pc_q      <= '0;
            if_pc4_q     <= '0;
            if_instr_q   <= NOP;
            skid_v_q     <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            ifv_q        <= ifv_d;
            if_pc_q      <= if_pc_d;
            if_pc4_q     <= if_pc4_d;
            if_instr_q   <= if_instr_d;
            skid_v_q     <= skid_v_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            mis_q        <= mis_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch-stage bench checked every cycle against a
// transaction-level model (fetched-instruction queue + one outstanding request).
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

    logic        clk = 0, rst = 1, stall = 0, redirect = 0, imem_gnt = 0, imem_rvalid = 0;
    logic [31:0] redirect_target = 0, imem_rdata = 0;
    logic        imem_req, if_id_valid, misaligned;
    logic [31:0] imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr;

    int checks = 0, passed = 0;

    ent_t        fq[$];
    logic [31:0] m_pc = 0, m_out_addr = 0, mem_addr = 0, mem_data = 0;
    bit          m_started = 0, m_out = 0, m_stale = 0, m_mis = 0;
    bit          mem_busy = 0, inj_rv = 0, rand_data = 0;
    int          mem_cnt = 0, gnt_pct = 100, lat_max = 1, stall_pct = 0, redir_pct = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr(if_id_instr), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // The stage fetches while it holds fewer than two instructions and nothing is in flight.
    function automatic bit exp_req();
        return m_started && !m_out && fq.size() < 2;
    endfunction

    task automatic model_reset();
        fq.delete();
        m_pc = 0; m_started = 0; m_out = 0; m_stale = 0; m_mis = 0; mem_busy = 0;
    endtask

    task automatic model_edge();
        bit grant, resp;
        grant = exp_req() && imem_gnt;
        resp  = m_out && imem_rvalid;
        m_mis = redirect && redirect_target[1:0] != 2'b00;
        if (grant) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(1, lat_max);
            mem_addr = m_pc;
            mem_data = rand_data ? $urandom : m_pc ^ 32'hA5;
        end
        if (!m_started) begin
            m_started = 1;
            if (redirect) m_pc = {redirect_target[31:2], 2'b00};
        end else if (redirect) begin
            fq.delete();
            m_pc = {redirect_target[31:2], 2'b00};
            if (grant) begin m_out = 1; m_stale = 1; end
            else if (resp) begin m_out = 0; m_stale = 0; end
            else if (m_out) m_stale = 1;
        end else begin
            if (!stall && fq.size() > 0) void'(fq.pop_front());
            if (resp) begin
                if (!m_stale) fq.push_back({m_out_addr, imem_rdata});
                m_out = 0; m_stale = 0;
            end
            if (grant) begin m_out = 1; m_out_addr = m_pc; m_pc = m_pc + 4; end
        end
    endtask

    task automatic drive(bit st, bit rd, logic [31:0] tg);
        stall = st; redirect = rd; redirect_target = tg;
        imem_gnt = $urandom_range(0, 99) < gnt_pct;
        imem_rvalid = 0;
        imem_rdata = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin imem_rvalid = 1; imem_rdata = mem_data; mem_busy = 0; end
        end else if (inj_rv || (!m_out && $urandom_range(0, 9) == 0)) imem_rvalid = 1;
    endtask

    task automatic check_all();
        chk("imem_req", imem_req, exp_req());
        if (exp_req()) chk("imem_addr", imem_addr, m_pc);
        chk("misaligned", misaligned, m_mis);
        chk("if_id_valid", if_id_valid, fq.size() > 0);
        if (fq.size() > 0) begin
            chk("if_id_pc", if_id_pc, fq[0].pc);
            chk("if_id_pc_plus4", if_id_pc_plus4, fq[0].pc + 4);
            chk("if_id_instr", if_id_instr, fq[0].instr);
        end
    endtask

    task automatic check_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_mis", misaligned, 0);
    endtask

    task automatic cycle(bit st, bit rd, logic [31:0] tg);
        drive(st, rd, tg);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_cycle();
        cycle($urandom_range(0, 99) < stall_pct, $urandom_range(0, 99) < redir_pct,
              32'($urandom_range(0, 4095)));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_reset();
        model_reset();
        rst = 0;
        repeat (12) cycle(0, 0, 0);
        repeat (6) cycle(1, 0, 0);
        repeat (6) cycle(0, 0, 0);
        lat_max = 3;
        for (int i = 0; i < 8 && !(m_out && !m_stale); i++) cycle(0, 0, 0);
        cycle(0, 1, 32'h100);
        repeat (8) cycle(0, 0, 0);
        cycle(0, 1, 32'h103);
        repeat (8) cycle(0, 0, 0);
        cycle(0, 1, 32'hFFFF_FFFC);
        repeat (8) cycle(0, 0, 0);
        gnt_pct = 60; stall_pct = 35; redir_pct = 4; rand_data = 1;
        repeat (3000) rand_cycle();
        redir_pct = 0; stall_pct = 0; gnt_pct = 100;
        for (int i = 0; i < 50 && !(m_out && !m_stale); i++) rand_cycle();
        chk("reach_wait", m_out && !m_stale, 1);
        #2 rst = 1;
        #1 check_reset();
        @(negedge clk);
        model_reset();
        rst = 0;
        inj_rv = 1;
        repeat (2) cycle(0, 0, 0);
        inj_rv = 0;
        repeat (30) rand_cycle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
